spike_perf_monitor: RTL and testbench
=====================================

Name: spike_perf_monitor

Overview:
- Synthesizable, parametrised monitor that replaces the bench-only throughput and latency bookkeeping around snn_layer.
- Taps the pre_spikes bus and the post_spikes bus of one layer. Over a programmed window it counts input events and output spikes, and accumulates input-to-output latency through a FIFO of timestamps matched oldest-first.
- Sits beside snn_layer. Results are read by the host or the bench once done is asserted.

Parameters:
- FAN_IN, 8, width of pre_spikes.
- NUM_OUT, 1, width of post_spikes.
- WINDOW_CYCLES, 200000, length of the measurement window in clocks; must be ≥1.
- CNT_W, 32, width of the cycle and event counters.
- LAT_W, 16, width of the latency value (cycles).
- ACC_W, 48, width of the latency accumulator.
- FIFO_DEPTH, 16, number of timestamp entries; must be a power of two and ≥2.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse: clear all results and begin a window.
- pre_spikes, input, FAN_IN, input spike vector, one bit per source.
- post_spikes, input, NUM_OUT, output spike vector.
- busy, output, 1, high while in RUN.
- done, output, 1, high in DONE.
- cycle_count, output, CNT_W, clocks elapsed in the current window.
- in_events, output, CNT_W, sum over the window of popcount(pre_spikes).
- out_spikes, output, CNT_W, sum over the window of popcount(post_spikes).
- lat_sum, output, ACC_W, sum of matched latencies.
- lat_samples, output, CNT_W, number of matched events.
- lat_last, output, LAT_W, latency of the most recent match.
- lat_max, output, LAT_W, largest latency matched in the window.
- drop_events, output, CNT_W, input events discarded because the FIFO was full.
- overflow, output, 1, sticky; set on the first drop.

Behaviour:
- Reset: state IDLE; every output 0; FIFO empty; internal timestamp counter 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1 → RUN.
  - RUN: on the cycle where cycle_count == WINDOW_CYCLES-1, the last sample is taken and the next state is DONE.
  - DONE, start=1 → RUN.
  - RUN, start=1 → restart: clear everything, remain in RUN, and treat that cycle as window cycle 0.
  - The cycle on which start is seen clears all results, the FIFO and the timestamp. Sampling begins on the following cycle.
- Sampling rule: samples are taken only in RUN. All outputs are registered and update one cycle after the sampled edge.
- FIFO entries hold {ts (LAT_W), cnt (clog2(FAN_IN+1) bits)}. The timestamp counter increments every RUN cycle and wraps naturally at LAT_W bits.
- Push: when popcount(pre_spikes) = p > 0, write {ts_now, p}. If the FIFO is full, do not write; add p to drop_events and set overflow.
- Match on each RUN cycle:
  - k = popcount(post_spikes); head entry h is taken from the FIFO state before this cycle's push.
  - m = min(k, h.cnt).
  - lat = ts_now - h.ts, computed modulo 2^LAT_W.
  - Update: h.cnt -= m; pop when it reaches 0; lat_sum += m*lat; lat_samples += m; lat_last = lat; lat_max = max(lat_max, lat).
  - Unmatched output spikes (k > m, or FIFO empty) are counted in out_spikes only. A match never spans two entries.
- Latency minimum is 1 cycle, because same-cycle inputs are not visible to the match.
- Simultaneous push and pop on a full FIFO: the pop frees a slot and the push succeeds, with no drop.
- Saturation: all CNT_W and ACC_W counters saturate at their maximum value and never wrap.
- Asynchronous reset in any state returns immediately to the reset values.

Optional Feature:
- Macro: SPIKE_MON_HIST_EN.
- When defined:
  - Adds output lat_hist, CNT_W*8 bits wide.
  - Bin i (i = 0..6) counts matches with lat in [2^i, 2^(i+1)). Bin 7 counts lat ≥ 128.
  - Each matched event adds m to its bin. Bins saturate, clear on start, and reset to 0.
- When not defined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package snn_mon_pkg holds:
  - fifo entry typedef;
  - popcount function;
  - FSM state enum;
  - HIST_BINS = 8 constant.
- Sub-module ts_fifo:
  - synchronous FIFO of FIFO_DEPTH entries;
  - push, pop, and a head-count decrement port;
  - full and empty flags.

Test Plan:
1. Reset, then start with WINDOW_CYCLES=10 and no spikes → busy for 10 cycles, then done=1, cycle_count=10, all other counters 0.
2. pre_spikes=8'b0000_0011 at window cycle 2, post_spikes=1 at cycle 5 → in_events=2, lat_samples=1, lat_last=3, lat_sum=3. Head cnt becomes 1. A second post spike at cycle 7 → lat_sum=8, lat_max=5.
3. Same-cycle input and output with an empty FIFO → out_spikes=1, lat_samples=0, one entry pushed.
4. FIFO_DEPTH=4, five consecutive input cycles with 1 event each and no outputs → drop_events=1, overflow=1. A pop and push on the same cycle when full → no further drop.
5. start asserted mid-RUN at cycle 50 → all counters 0 on the next cycle, and the window runs a further WINDOW_CYCLES cycles. Assert rst_n in DONE → all outputs 0 asynchronously.
6. With SPIKE_MON_HIST_EN defined, latencies 1, 3, 200 → bin0=1, bin1=1, bin7=1, all other bins 0.

Source files
------------

// File: rtl/snn_mon_pkg.sv
// snn_mon_pkg: shared types and helpers for the spike performance monitor
//   HIST_BINS  - number of latency histogram bins
//   POP_MAX    - widest vector popcount accepts (callers zero-extend)
//   mon_state_t, ts_entry_t, popcount()
package snn_mon_pkg;
    localparam int HIST_BINS = 8;
    localparam int POP_MAX = 1024;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mon_state_t;
    // ts holds the LAT_W-bit timestamp zero-extended; cnt holds the pending event count
    typedef struct packed {
        logic [31:0] ts;
        logic [15:0] cnt;
    } ts_entry_t;
    function automatic logic [15:0] popcount(input logic [POP_MAX-1:0] v);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX; i++) n = n + 16'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/ts_fifo.sv
// ts_fifo: timestamp FIFO with in-place decrement of the head entry count
//   clk, rst_n      - clock, asynchronous active-low reset
//   clr             - synchronous flush
//   push/din        - write an entry (caller guarantees space, or a same-cycle pop)
//   pop             - discard the head entry
//   dec/dec_val     - subtract dec_val from the head count without popping
//   head/full/empty - head entry and occupancy flags
module ts_fifo
    import snn_mon_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        push,
    input  ts_entry_t   din,
    input  logic        pop,
    input  logic        dec,
    input  logic [15:0] dec_val,
    output ts_entry_t   head,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);
    ts_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [AW:0] r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd <= '0;
            r_wr <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_rd <= '0;
            r_wr <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wr <= r_wr + 1'b1;
            if (pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    // A push can only alias the head slot when the FIFO is full with a pop, so dec is idle then
    always_ff @(posedge clk) begin
        if (dec) r_mem[r_rd].cnt <= r_mem[r_rd].cnt - dec_val;
        if (push) r_mem[r_wr] <= din;
    end
    assign head = r_mem[r_rd];
    assign empty = (r_count == '0);
    assign full = (r_count == (AW+1)'(DEPTH));
endmodule

// File: rtl/spike_perf_monitor.sv
// spike_perf_monitor: windowed spike throughput and input-to-output latency monitor
//   clk, rst_n       - clock, asynchronous active-low reset
//   start            - pulse: clear results and (re)start a window
//   pre_spikes       - FAN_IN input spike vector
//   post_spikes      - NUM_OUT output spike vector
//   busy, done       - window running / window finished
//   cycle_count, in_events, out_spikes, drop_events, overflow - throughput results
//   lat_sum, lat_samples, lat_last, lat_max - latency results
//   lat_hist         - latency histogram, present only with SPIKE_MON_HIST_EN defined
module spike_perf_monitor
    import snn_mon_pkg::*;
#(
    parameter int FAN_IN = 8,
    parameter int NUM_OUT = 1,
    parameter int WINDOW_CYCLES = 200000,
    parameter int CNT_W = 32,
    parameter int LAT_W = 16,
    parameter int ACC_W = 48,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [FAN_IN-1:0]    pre_spikes,
    input  logic [NUM_OUT-1:0]   post_spikes,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     in_events,
    output logic [CNT_W-1:0]     out_spikes,
    output logic [ACC_W-1:0]     lat_sum,
    output logic [CNT_W-1:0]     lat_samples,
    output logic [LAT_W-1:0]     lat_last,
    output logic [LAT_W-1:0]     lat_max,
    output logic [CNT_W-1:0]     drop_events,
    output logic                 overflow
`ifdef SPIKE_MON_HIST_EN
    ,
    output logic [HIST_BINS*CNT_W-1:0] lat_hist
`endif
);
    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction
    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction
    mon_state_t r_state, w_next;
    logic [CNT_W-1:0] r_cycle, r_in, r_out, r_samples, r_drop;
    logic [ACC_W-1:0] r_sum;
    logic [LAT_W-1:0] r_ts, r_last, r_max, w_lat;
    logic r_ovf;
    logic [15:0] w_p, w_k, w_m;
    ts_entry_t w_head, w_din;
    logic w_full, w_empty, w_sample, w_hit, w_pop, w_dec, w_push, w_drop;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (start) w_next = RUN;
        else if (r_state == RUN && r_cycle == CNT_W'(WINDOW_CYCLES - 1)) w_next = DONE;
    end
    // The start cycle only clears; sampling begins the cycle after
    assign w_sample = (r_state == RUN) && !start;
    assign w_p = popcount(POP_MAX'(pre_spikes));
    assign w_k = popcount(POP_MAX'(post_spikes));
    // Head is the pre-push FIFO state, so same-cycle inputs never match (latency >= 1)
    assign w_m = w_empty ? 16'd0 : (w_k < w_head.cnt ? w_k : w_head.cnt);
    assign w_lat = LAT_W'(32'(r_ts) - w_head.ts);
    assign w_hit = w_sample && (w_m != 16'd0);
    assign w_pop = w_hit && (w_m == w_head.cnt);
    assign w_dec = w_hit && !w_pop;
    // A same-cycle pop frees a slot on a full FIFO
    assign w_push = w_sample && (w_p != 16'd0) && (!w_full || w_pop);
    assign w_drop = w_sample && (w_p != 16'd0) && w_full && !w_pop;
    assign w_din = '{ts: 32'(r_ts), cnt: w_p};
    ts_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start),
        .push    (w_push),
        .din     (w_din),
        .pop     (w_pop),
        .dec     (w_dec),
        .dec_val (w_m),
        .head    (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle <= '0;
            r_ts <= '0;
            r_in <= '0;
            r_out <= '0;
            r_sum <= '0;
            r_samples <= '0;
            r_last <= '0;
            r_max <= '0;
            r_drop <= '0;
            r_ovf <= 1'b0;
        end else if (start) begin
            r_cycle <= '0;
            r_ts <= '0;
            r_in <= '0;
            r_out <= '0;
            r_sum <= '0;
            r_samples <= '0;
            r_last <= '0;
            r_max <= '0;
            r_drop <= '0;
            r_ovf <= 1'b0;
        end else if (w_sample) begin
            r_cycle <= sat_cnt(r_cycle, CNT_W'(1));
            r_ts <= r_ts + 1'b1;
            r_in <= sat_cnt(r_in, CNT_W'(w_p));
            r_out <= sat_cnt(r_out, CNT_W'(w_k));
            if (w_hit) begin
                r_sum <= sat_acc(r_sum, ACC_W'(w_m) * ACC_W'(w_lat));
                r_samples <= sat_cnt(r_samples, CNT_W'(w_m));
                r_last <= w_lat;
                r_max <= (w_lat > r_max) ? w_lat : r_max;
            end
            if (w_drop) begin
                r_drop <= sat_cnt(r_drop, CNT_W'(w_p));
                r_ovf <= 1'b1;
            end
        end
    end
    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign cycle_count = r_cycle;
    assign in_events = r_in;
    assign out_spikes = r_out;
    assign lat_sum = r_sum;
    assign lat_samples = r_samples;
    assign lat_last = r_last;
    assign lat_max = r_max;
    assign drop_events = r_drop;
    assign overflow = r_ovf;
`ifdef SPIKE_MON_HIST_EN
    logic [CNT_W-1:0] r_hist [HIST_BINS];
    logic [2:0] w_bin;
    // Bin = floor(log2(lat)), clamped to the last bin; lat 0 (wrapped timestamp) is not binned
    always_comb begin
        w_bin = '0;
        for (int b = 1; b < HIST_BINS; b++) if (w_lat >= (LAT_W'(1) << b)) w_bin = 3'(b);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < HIST_BINS; b++) r_hist[b] <= '0;
        end else if (start) begin
            for (int b = 0; b < HIST_BINS; b++) r_hist[b] <= '0;
        end else if (w_hit && w_lat != '0) begin
            r_hist[w_bin] <= sat_cnt(r_hist[w_bin], CNT_W'(w_m));
        end
    end
    for (genvar i = 0; i < HIST_BINS; i++) begin : g_hist
        assign lat_hist[i*CNT_W +: CNT_W] = r_hist[i];
    end
`endif
endmodule

// File: tb/tb_spike_perf_monitor.sv
// tb_spike_perf_monitor: directed and randomized checks against a queue-based reference model
module tb_spike_perf_monitor;
    localparam int FI = 8, NO = 2, WIN = 300, CW = 32, LW = 16, AW = 48, DEP = 4;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [FI-1:0] pre = '0;
    logic [NO-1:0] post = '0;
    logic busy, done, overflow;
    logic [CW-1:0] cycle_count, in_events, out_spikes, lat_samples, drop_events;
    logic [AW-1:0] lat_sum;
    logic [LW-1:0] lat_last, lat_max;
`ifdef SPIKE_MON_HIST_EN
    logic [8*CW-1:0] lat_hist;
`endif
    always #5 clk = ~clk;
    spike_perf_monitor #(
        .FAN_IN(FI), .NUM_OUT(NO), .WINDOW_CYCLES(WIN), .CNT_W(CW),
        .LAT_W(LW), .ACC_W(AW), .FIFO_DEPTH(DEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pre_spikes(pre), .post_spikes(post),
        .busy(busy), .done(done), .cycle_count(cycle_count), .in_events(in_events),
        .out_spikes(out_spikes), .lat_sum(lat_sum), .lat_samples(lat_samples),
        .lat_last(lat_last), .lat_max(lat_max), .drop_events(drop_events), .overflow(overflow)
`ifdef SPIKE_MON_HIST_EN
        , .lat_hist(lat_hist)
`endif
    );
    typedef struct {int ts; int cnt;} ent_t;
    ent_t q[$];
    int m_running, m_done;
    longint m_cyc, m_in, m_out, m_sum, m_samp, m_drop, m_last, m_max, m_ts;
    longint m_hist[8];
    bit m_ovf;
    int checks = 0, failures = 0;
    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic model_clear();
        q.delete();
        m_cyc = 0; m_in = 0; m_out = 0; m_sum = 0; m_samp = 0; m_drop = 0;
        m_last = 0; m_max = 0; m_ts = 0; m_ovf = 0;
        for (int b = 0; b < 8; b++) m_hist[b] = 0;
    endtask
    task automatic model_step(input logic [FI-1:0] p_in, input logic [NO-1:0] s_in, input bit st);
        int p, k, m, lat;
        if (st) begin
            model_clear();
            m_running = 1; m_done = 0;
            return;
        end
        if (!m_running) return;
        p = $countones(p_in);
        k = $countones(s_in);
        if (q.size() > 0) begin
            m = (k < q[0].cnt) ? k : q[0].cnt;
            if (m > 0) begin
                lat = int'((m_ts - q[0].ts) % 65536);
                m_sum += m * lat;
                m_samp += m;
                m_last = lat;
                if (lat > m_max) m_max = lat;
                if (lat >= 128) m_hist[7] += m;
                else if (lat > 0) m_hist[$clog2(lat + 1) - 1] += m;
                q[0].cnt -= m;
                if (q[0].cnt == 0) void'(q.pop_front());
            end
        end
        if (p > 0) begin
            if (q.size() < DEP) q.push_back('{int'(m_ts), p});
            else begin
                m_drop += p;
                m_ovf = 1;
            end
        end
        m_in += p;
        m_out += k;
        m_cyc++;
        m_ts = (m_ts + 1) % 65536;
        if (m_cyc == WIN) begin
            m_running = 0;
            m_done = 1;
        end
    endtask
    task automatic check_all();
        chk("busy", longint'(busy), longint'(m_running));
        chk("done", longint'(done), longint'(m_done));
        chk("cycle_count", longint'(cycle_count), m_cyc);
        chk("in_events", longint'(in_events), m_in);
        chk("out_spikes", longint'(out_spikes), m_out);
        chk("lat_sum", longint'(lat_sum), m_sum);
        chk("lat_samples", longint'(lat_samples), m_samp);
        chk("lat_last", longint'(lat_last), m_last);
        chk("lat_max", longint'(lat_max), m_max);
        chk("drop_events", longint'(drop_events), m_drop);
        chk("overflow", longint'(overflow), longint'(m_ovf));
`ifdef SPIKE_MON_HIST_EN
        for (int b = 0; b < 8; b++) chk($sformatf("hist_bin%0d", b), longint'(lat_hist[b*CW +: CW]), m_hist[b]);
`endif
    endtask
    task automatic step(input logic [FI-1:0] p_in, input logic [NO-1:0] s_in, input bit st);
        pre = p_in;
        post = s_in;
        start = st;
        model_step(p_in, s_in, st);
        @(negedge clk);
        check_all();
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0);
    endtask
    task automatic rnd(input int n);
        for (int i = 0; i < n; i++)
            step(($urandom_range(0, 2) == 0) ? FI'($urandom) : '0,
                 ($urandom_range(0, 2) == 0) ? NO'($urandom) : '0, 1'b0);
    endtask
    initial begin
        m_running = 0; m_done = 0;
        model_clear();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        // empty window: busy for WIN cycles then done with only the cycle count set
        step('0, '0, 1'b1);
        chk("t1_busy_after_start", longint'(busy), 1);
        idle(WIN);
        chk("t1_done", longint'(done), 1);
        chk("t1_cycles", longint'(cycle_count), WIN);
        // two inputs at cycle 2, outputs at 5 and 7
        step('0, '0, 1'b1);
        idle(2);
        step(8'b0000_0011, '0, 1'b0);
        idle(2);
        step('0, 2'b01, 1'b0);
        chk("t2_in_events", longint'(in_events), 2);
        chk("t2_lat_last", longint'(lat_last), 3);
        chk("t2_lat_sum", longint'(lat_sum), 3);
        idle(1);
        step('0, 2'b01, 1'b0);
        chk("t2_lat_sum2", longint'(lat_sum), 8);
        chk("t2_lat_max", longint'(lat_max), 5);
        // same-cycle input and output never match
        step('0, '0, 1'b1);
        step(8'h01, 2'b01, 1'b0);
        chk("t3_out_spikes", longint'(out_spikes), 1);
        chk("t3_lat_samples", longint'(lat_samples), 0);
        step('0, 2'b01, 1'b0);
        chk("t3_later_match", longint'(lat_last), 1);
        // overflow on a depth-4 FIFO, then pop+push while full
        step('0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step(8'h10, '0, 1'b0);
        chk("t4_drop", longint'(drop_events), 1);
        chk("t4_overflow", longint'(overflow), 1);
        step(8'h10, 2'b10, 1'b0);
        chk("t4_no_drop_on_pop", longint'(drop_events), 1);
        // histogram latencies 1, 3 and 200
        step('0, '0, 1'b1);
        step(8'h01, '0, 1'b0);
        step('0, 2'b01, 1'b0);
        step(8'h02, '0, 1'b0);
        idle(2);
        step('0, 2'b10, 1'b0);
        step(8'h04, '0, 1'b0);
        idle(199);
        step('0, 2'b01, 1'b0);
        chk("t6_lat_last", longint'(lat_last), 200);
`ifdef SPIKE_MON_HIST_EN
        chk("t6_bin0", longint'(lat_hist[0*CW +: CW]), 1);
        chk("t6_bin1", longint'(lat_hist[1*CW +: CW]), 1);
        chk("t6_bin7", longint'(lat_hist[7*CW +: CW]), 1);
`endif
        // restart mid-run at cycle 50, then finish the window
        step('0, '0, 1'b1);
        rnd(50);
        step(8'hFF, 2'b11, 1'b1);
        chk("t5_restart_cycles", longint'(cycle_count), 0);
        chk("t5_restart_in", longint'(in_events), 0);
        rnd(WIN - 1);
        chk("t5_still_busy", longint'(busy), 1);
        rnd(1);
        chk("t5_done", longint'(done), 1);
        // asynchronous reset while in DONE
        #2 rst_n = 1'b0;
        m_running = 0; m_done = 0;
        model_clear();
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        // randomized full window with frequent overflow
        step('0, '0, 1'b1);
        rnd(WIN + 5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
